// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared funct3 codes, RAM width codes, LSU state encoding and
//          request legality helpers for the load/store unit.
// Rev    : 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_FAULT = 2'd3
    } lsu_state_e;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Only meaningful for a legal funct3; callers gate it with f3_legal.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
        return ((f3[1:0] == WIDTH_HALF) && lsb[0]) ||
               ((f3[1:0] == WIDTH_WORD) && (lsb != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_extend.sv
`default_nettype none
// ============================================================================
// Module : lsu_extend
// Brief  : Sign/zero extension of a zero-extended RAM read by load funct3.
// Rev    : 1.0
// ============================================================================
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic [2:0]      funct3,
    input  logic [WORD-1:0] raw,
    output logic [WORD-1:0] ext
);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{(WORD-8){raw[7]}}, raw[7:0]};
            F3_H:    ext = {{(WORD-16){raw[15]}}, raw[15:0]};
            F3_BU:   ext = {{(WORD-8){1'b0}}, raw[7:0]};
            F3_HU:   ext = {{(WORD-16){1'b0}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module : lsu
// Brief  : Single-outstanding RV32I load/store unit in front of the data RAM.
// Rev    : 1.0
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int WORD = 32,
    parameter int ADDR = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [ADDR-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [WORD-1:0] resp_rdata,
    output logic            resp_misalign,
    output logic            resp_illegal,
    output logic [ADDR-1:0] mem_addr,
    output logic [1:0]      mem_width,
    output logic            mem_write,
    output logic [WORD-1:0] mem_din,
    input  logic [WORD-1:0] mem_dout
);

    lsu_state_e      r_state;
    lsu_state_e      w_state_next;
    logic            r_store;
    logic [2:0]      r_funct3;
    logic [ADDR-1:0] r_addr;
    logic [WORD-1:0] r_wdata;

    logic            w_accept;
    logic            w_in_fault;
    logic            w_illegal;
    logic            w_misalign;
    logic [WORD-1:0] w_ext;

    assign w_accept   = req_valid && req_ready;
    assign w_in_fault = !f3_legal(req_store, req_funct3) ||
                        is_misaligned(req_funct3, req_addr[1:0]);

    // Fault flags are re-derived from the held request so they stay stable.
    assign w_illegal  = !f3_legal(r_store, r_funct3);
    assign w_misalign = !w_illegal && is_misaligned(r_funct3, r_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_store  <= req_store;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_state_next = w_in_fault ? ST_FAULT : ST_ISSUE;
            end
            ST_ISSUE: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    w_state_next = ST_IDLE;
            end
            ST_FAULT: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    lsu_extend #(
        .WORD (WORD)
    ) u_extend (
        .funct3 (r_funct3),
        .raw    (mem_dout),
        .ext    (w_ext)
    );

    assign resp_rdata    = ((r_state == ST_RESP) && !r_store) ? w_ext : '0;
    assign resp_misalign = (r_state == ST_FAULT) && w_misalign;
    assign resp_illegal  = (r_state == ST_FAULT) && w_illegal;

    assign mem_addr  = r_addr;
    assign mem_width = r_funct3[1:0];
    assign mem_din   = r_wdata;
    // rst gates the strobe directly so a reset landing in ISSUE cancels the write.
    assign mem_write = (r_state == ST_ISSUE) && r_store && !rst;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module : tb_lsu
// Brief  : Self-checking bench for lsu with a byte RAM and a reference memory.
// Rev    : 1.0
// ============================================================================
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        resp_illegal;
    logic [31:0] mem_addr;
    logic [1:0]  mem_width;
    logic        mem_write;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;

    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];

    lsu #(.WORD(32), .ADDR(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .resp_illegal  (resp_illegal),
        .mem_addr      (mem_addr),
        .mem_width     (mem_width),
        .mem_write     (mem_write),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed RAM, little-endian, registered zero-extended read.
    always @(posedge clk) begin
        if (mem_write) begin
            wr_count <= wr_count + 1;
            ram[mem_addr[7:0]] <= mem_din[7:0];
            if (mem_width != 2'b00) ram[8'(mem_addr[7:0] + 8'd1)] <= mem_din[15:8];
            if (mem_width[1]) begin
                ram[8'(mem_addr[7:0] + 8'd2)] <= mem_din[23:16];
                ram[8'(mem_addr[7:0] + 8'd3)] <= mem_din[31:24];
            end
        end else begin
            case (mem_width)
                2'b00:   mem_dout <= {24'd0, ram[mem_addr[7:0]]};
                2'b01:   mem_dout <= {16'd0, ram[8'(mem_addr[7:0] + 8'd1)], ram[mem_addr[7:0]]};
                default: mem_dout <= {ram[8'(mem_addr[7:0] + 8'd3)], ram[8'(mem_addr[7:0] + 8'd2)],
                                      ram[8'(mem_addr[7:0] + 8'd1)], ram[mem_addr[7:0]]};
            endcase
        end
    end

    function automatic int unsigned size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit exp_illegal(input bit st, input logic [2:0] f3);
        if (st) return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic bit exp_misalign(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (exp_illegal(st, f3)) return 1'b0;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned v = 0;
        int unsigned n = size_of(f3);
        for (int unsigned i = 0; i < n; i++)
            v = v + ref_mem[(a + i) % 256] * (1 << (8 * i));
        if (f3 == 3'd0 && v >= 128)   v = v + 32'hFFFF_FF00;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
        return 32'(v);
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int unsigned i = 0; i < size_of(f3); i++)
            ref_mem[(a + i) % 256] = 8'((wd >> (8 * i)) % 256);
    endtask

    // Issues one request, checks timing/payload/stall stability, then completes it.
    task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int stall, input string tag);
        bit          ill   = exp_illegal(st, f3);
        bit          mis   = exp_misalign(st, f3, a);
        bit          fault = ill || mis;
        logic [31:0] exp_d = (fault || st) ? 32'd0 : model_load(f3, a);
        int          wc0;
        logic [31:0] held;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        resp_ready = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s req_ready idle: got %b want 1", tag, req_ready); end
        wc0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!fault) begin
            n_checks++;
            if (resp_valid !== 1'b0 || mem_write !== st) begin
                n_fail++;
                $display("FAIL %s issue cycle: resp_valid=%b mem_write=%b want 0/%b", tag, resp_valid, mem_write, st);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== exp_d || resp_misalign !== mis || resp_illegal !== ill) begin
            n_fail++;
            $display("FAIL %s response: valid=%b rdata=%h mis=%b ill=%b want 1/%h/%b/%b",
                     tag, resp_valid, resp_rdata, resp_misalign, resp_illegal, exp_d, mis, ill);
        end
        held = resp_rdata;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0 || mem_write !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall %0d: valid=%b rdata=%h req_ready=%b wr=%b want 1/%h/0/0",
                         tag, k, resp_valid, resp_rdata, req_ready, mem_write, held);
            end
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || (wr_count - wc0) != ((st && !fault) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s completion: valid=%b req_ready=%b writes=%0d want 0/1/%0d",
                     tag, resp_valid, req_ready, wr_count - wc0, (st && !fault) ? 1 : 0);
        end
        if (st && !fault) model_store(f3, a, wd);
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_misalign !== 1'b0 ||
            resp_illegal !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'd0 || mem_width !== 2'b00 ||
            mem_din !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b v=%b d=%h mis=%b ill=%b wr=%b a=%h w=%b din=%h",
                     req_ready, resp_valid, resp_rdata, resp_misalign, resp_illegal,
                     mem_write, mem_addr, mem_width, mem_din);
        end
    endtask

    task automatic test_loads_stores;
        run_access(1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, "sw_10");
        run_access(0, 3'd2, 32'h10, 32'h0, 0, "lw_10");
        run_access(1, 3'd0, 32'h20, 32'h0000_0080, 0, "sb_20");
        run_access(0, 3'd0, 32'h20, 32'h0, 0, "lb_20");
        run_access(0, 3'd4, 32'h20, 32'h0, 0, "lbu_20");
        run_access(1, 3'd1, 32'h30, 32'h0000_8001, 0, "sh_30");
        run_access(0, 3'd1, 32'h30, 32'h0, 0, "lh_30");
        run_access(0, 3'd5, 32'h30, 32'h0, 0, "lhu_30");
    endtask

    task automatic test_faults;
        run_access(0, 3'd2, 32'h12, 32'h0, 0, "lw_misalign");
        run_access(1, 3'd1, 32'h31, 32'hFFFF_FFFF, 2, "sh_misalign");
        run_access(0, 3'd3, 32'h13, 32'h0, 0, "ld_illegal");
        run_access(1, 3'd4, 32'h20, 32'h1234_5678, 1, "st_illegal");
        run_access(0, 3'd2, 32'h30, 32'h0, 0, "lw_30_after_faults");
    endtask

    task automatic test_stall;
        run_access(0, 3'd2, 32'h10, 32'h0, 5, "lw_stall5");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; resp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== model_load(3'd2, 32'h10)) begin
            n_fail++; $display("FAIL b2b_first: valid=%b rdata=%h want 1/%h", resp_valid, resp_rdata, model_load(3'd2, 32'h10));
        end
        @(negedge clk);
        resp_ready = 1'b1; req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h50; req_wdata = 32'h0000_005A;
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_not_same_cycle: valid=%b req_ready=%b want 0/1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; resp_ready = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 32'h50) begin
            n_fail++; $display("FAIL b2b_accept: req_ready=%b wr=%b addr=%h want 0/1/50", req_ready, mem_write, mem_addr);
        end
        @(posedge clk); #1;
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        model_store(3'd0, 32'h50, 32'h5A);
        run_access(0, 3'd4, 32'h50, 32'h0, 0, "lbu_50");
    endtask

    task automatic test_reset_during_issue;
        int wc0;
        run_access(1, 3'd2, 32'h40, 32'hCAFE_F00D, 0, "sw_40_prior");
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h1234_5678;
        wc0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_issue_write: mem_write=%b want 0", mem_write); end
        @(posedge clk); #1 rst = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || mem_addr !== 32'd0 ||
            mem_width !== 2'b00 || mem_din !== 32'd0 || mem_write !== 1'b0 || wr_count != wc0) begin
            n_fail++;
            $display("FAIL rst_issue_outputs: rdy=%b v=%b d=%h a=%h w=%b din=%h wr=%b writes=%0d",
                     req_ready, resp_valid, resp_rdata, mem_addr, mem_width, mem_din, mem_write, wr_count - wc0);
        end
        run_access(0, 3'd2, 32'h40, 32'h0, 0, "lw_40_after_rst");
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            bit          st = 1'($urandom_range(0, 1));
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom_range(0, 255);
            if ($urandom_range(0, 2) != 0) a = a & ~(size_of(f3) - 1);
            run_access(st, f3, a, $urandom, $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_ram_contents;
        int bad = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL ram_contents: %0d bytes differ, want 0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        mem_dout = 32'd0;
        test_reset;
        test_loads_stores;
        test_faults;
        test_stall;
        test_back_to_back;
        test_reset_during_issue;
        test_random;
        test_ram_contents;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
